// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-to-sequencer bundle: register addresses and hazard inputs in, stage controls out.
// The master side drives the pipeline observations; the slave side is the sequencer.
interface hazard_ctrl_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       i_rs1_addr_D;
  logic [4:0]       i_rs2_addr_D;
  logic [4:0]       i_rs1_addr_E;
  logic [4:0]       i_rs2_addr_E;
  logic [4:0]       i_rd_addr_E;
  logic             i_rd_wren_E;
  logic [1:0]       i_wb_sel_E;
  logic [4:0]       i_rd_addr_M;
  logic             i_rd_wren_M;
  logic [4:0]       i_rd_addr_W;
  logic             i_rd_wren_W;
  logic             i_br_taken_E;
  logic             i_mc_op_E;
  logic             i_mc_done;
  logic [1:0]       o_forwardA_E;
  logic [1:0]       o_forwardB_E;
  logic             o_hold_pc;
  logic             o_hold_fd;
  logic             o_flush_fd;
  logic             o_hold_de;
  logic             o_flush_de;
  logic             o_hold_em;
  logic             o_flush_em;
  logic             o_mc_req;
  logic             o_mc_err;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_rs1_addr_D, i_rs2_addr_D, i_rs1_addr_E, i_rs2_addr_E,
    output i_rd_addr_E, i_rd_wren_E, i_wb_sel_E,
    output i_rd_addr_M, i_rd_wren_M, i_rd_addr_W, i_rd_wren_W,
    output i_br_taken_E, i_mc_op_E, i_mc_done,
    input  o_forwardA_E, o_forwardB_E,
    input  o_hold_pc, o_hold_fd, o_flush_fd, o_hold_de, o_flush_de, o_hold_em, o_flush_em,
    input  o_mc_req, o_mc_err, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_rs1_addr_D, i_rs2_addr_D, i_rs1_addr_E, i_rs2_addr_E,
    input  i_rd_addr_E, i_rd_wren_E, i_wb_sel_E,
    input  i_rd_addr_M, i_rd_wren_M, i_rd_addr_W, i_rd_wren_W,
    input  i_br_taken_E, i_mc_op_E, i_mc_done,
    output o_forwardA_E, o_forwardB_E,
    output o_hold_pc, o_hold_fd, o_flush_fd, o_hold_de, o_flush_de, o_hold_em, o_flush_em,
    output o_mc_req, o_mc_err, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// 5-stage pipeline sequencer: forwarding selects, load-use/branch hazards, multi-cycle unit scheduling.
// Controls are combinational from current inputs and state; the multi-cycle op stalls the front end until done or timeout.
module hazard_ctrl_unit #(
  parameter logic [1:0] WB_LSU     = 2'b01,
  parameter int         MC_TIMEOUT = 64,
  parameter int         CNT_W      = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  hazard_ctrl_unit_if.slave  bus
);

  localparam int WAIT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  typedef enum logic {
    S_RUN,
    S_MC_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mc_err_q, mc_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic       load_use;
  logic       mc_timeout;
  logic       hold_pc, hold_fd, flush_fd, hold_de, flush_de, flush_em, mc_req;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wren_m,
    input logic [4:0] rd_m,
    input logic       wren_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wren_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b01;
    end else if (wren_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  assign load_use = bus.i_rd_wren_E && (bus.i_wb_sel_E == WB_LSU) && (bus.i_rd_addr_E != 5'd0) &&
                    ((bus.i_rd_addr_E == bus.i_rs1_addr_D) || (bus.i_rd_addr_E == bus.i_rs2_addr_D));

  assign mc_timeout = (wait_cnt_q == WAIT_W'(MC_TIMEOUT - 1));

  // Forwarding is forced to the regfile while reset holds the pipeline.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!i_rst) begin
      fwd_a = fwd_sel(bus.i_rs1_addr_E, bus.i_rd_wren_M, bus.i_rd_addr_M, bus.i_rd_wren_W, bus.i_rd_addr_W);
      fwd_b = fwd_sel(bus.i_rs2_addr_E, bus.i_rd_wren_M, bus.i_rd_addr_M, bus.i_rd_wren_W, bus.i_rd_addr_W);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      mc_err_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mc_err_q    <= mc_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mc_err_d   = mc_err_q;
    case (state_q)
      S_RUN: begin
        if (bus.i_mc_op_E && !bus.i_br_taken_E) begin
          state_d    = S_MC_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_MC_WAIT: begin
        // A result arriving on the timeout cycle still completes the op.
        if (bus.i_mc_done) begin
          state_d = S_RUN;
        end else if (mc_timeout) begin
          state_d  = S_RUN;
          mc_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    hold_pc  = 1'b0;
    hold_fd  = 1'b0;
    flush_fd = 1'b0;
    hold_de  = 1'b0;
    flush_de = 1'b0;
    flush_em = 1'b0;
    mc_req   = 1'b0;
    if (i_rst) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
      flush_em = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          // Branch wins over everything; a multi-cycle op in E cannot be a load, so it precedes load-use.
          if (bus.i_br_taken_E) begin
            flush_fd = 1'b1;
            flush_de = 1'b1;
          end else if (bus.i_mc_op_E) begin
            mc_req   = 1'b1;
            hold_pc  = 1'b1;
            hold_fd  = 1'b1;
            hold_de  = 1'b1;
            flush_em = 1'b1;
          end else if (load_use) begin
            hold_pc  = 1'b1;
            hold_fd  = 1'b1;
            flush_de = 1'b1;
          end
        end
        S_MC_WAIT: begin
          if (!bus.i_mc_done) begin
            if (mc_timeout) begin
              flush_de = 1'b1;
              flush_em = 1'b1;
            end else begin
              hold_pc  = 1'b1;
              hold_fd  = 1'b1;
              hold_de  = 1'b1;
              flush_em = 1'b1;
            end
          end
        end
        default: begin
          flush_em = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold_pc && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_fd && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.o_forwardA_E = fwd_a;
  assign bus.o_forwardB_E = fwd_b;
  assign bus.o_hold_pc    = hold_pc;
  assign bus.o_hold_fd    = hold_fd;
  assign bus.o_flush_fd   = flush_fd;
  assign bus.o_hold_de    = hold_de;
  assign bus.o_flush_de   = flush_de;
  assign bus.o_hold_em    = 1'b0;
  assign bus.o_flush_em   = flush_em;
  assign bus.o_mc_req     = mc_req;
  assign bus.o_mc_err     = mc_err_q;
  assign bus.o_stall_cnt  = stall_cnt_q;
  assign bus.o_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: expected control words are queued per cycle and checked at the falling edge.
module tb_hazard_ctrl_unit;
  localparam int MC_TO = 64;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  hazard_ctrl_unit_if #(.CNT_W(32)) bus ();

  hazard_ctrl_unit #(
    .WB_LSU     (2'b01),
    .MC_TIMEOUT (MC_TO),
    .CNT_W      (32)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        hpc;
    logic        hfd;
    logic        ffd;
    logic        hde;
    logic        fde;
    logic        hem;
    logic        fem;
    logic        req;
    logic        err;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_flush = '0;
  logic        exp_err = 1'b0;

  function automatic exp_t e_base();
    exp_t e;
    e     = '0;
    e.sc  = exp_stall;
    e.fc  = exp_flush;
    e.err = exp_err;
    return e;
  endfunction

  function automatic exp_t e_reset();
    exp_t e;
    e     = e_base();
    e.ffd = 1'b1;
    e.fde = 1'b1;
    e.fem = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_mchold();
    exp_t e;
    e     = e_base();
    e.hpc = 1'b1;
    e.hfd = 1'b1;
    e.hde = 1'b1;
    e.fem = 1'b1;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clr();
    bus.i_rs1_addr_D = '0;
    bus.i_rs2_addr_D = '0;
    bus.i_rs1_addr_E = '0;
    bus.i_rs2_addr_E = '0;
    bus.i_rd_addr_E  = '0;
    bus.i_rd_wren_E  = 1'b0;
    bus.i_wb_sel_E   = 2'b00;
    bus.i_rd_addr_M  = '0;
    bus.i_rd_wren_M  = 1'b0;
    bus.i_rd_addr_W  = '0;
    bus.i_rd_wren_W  = 1'b0;
    bus.i_br_taken_E = 1'b0;
    bus.i_mc_op_E    = 1'b0;
    bus.i_mc_done    = 1'b0;
  endtask

  // One clock: queue the expectation, compare mid-cycle, advance the counter model, move past the next edge.
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(negedge i_clk);
    got = sb.pop_front();
    cmp({tag, ".fwdA"},     32'(bus.o_forwardA_E), 32'(got.fa));
    cmp({tag, ".fwdB"},     32'(bus.o_forwardB_E), 32'(got.fb));
    cmp({tag, ".hold_pc"},  32'(bus.o_hold_pc),    32'(got.hpc));
    cmp({tag, ".hold_fd"},  32'(bus.o_hold_fd),    32'(got.hfd));
    cmp({tag, ".flush_fd"}, 32'(bus.o_flush_fd),   32'(got.ffd));
    cmp({tag, ".hold_de"},  32'(bus.o_hold_de),    32'(got.hde));
    cmp({tag, ".flush_de"}, 32'(bus.o_flush_de),   32'(got.fde));
    cmp({tag, ".hold_em"},  32'(bus.o_hold_em),    32'(got.hem));
    cmp({tag, ".flush_em"}, 32'(bus.o_flush_em),   32'(got.fem));
    cmp({tag, ".mc_req"},   32'(bus.o_mc_req),     32'(got.req));
    cmp({tag, ".mc_err"},   32'(bus.o_mc_err),     32'(got.err));
    cmp({tag, ".stall"},    bus.o_stall_cnt,       got.sc);
    cmp({tag, ".flush"},    bus.o_flush_cnt,       got.fc);
    if (i_rst) begin
      exp_stall = '0;
      exp_flush = '0;
      exp_err   = 1'b0;
    end else begin
      if (got.hpc) exp_stall = exp_stall + 32'd1;
      if (got.ffd) exp_flush = exp_flush + 32'd1;
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    exp_t e;
    clr();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;

    // Reset masks forwarding and the mc request even with hazards present.
    bus.i_rd_wren_M = 1'b1; bus.i_rd_addr_M = 5'd5; bus.i_rs1_addr_E = 5'd5; bus.i_mc_op_E = 1'b1;
    step("rst0", e_reset());
    step("rst1", e_reset());
    i_rst = 1'b0;

    // 1) M forwarding, and x0 never forwards.
    clr(); bus.i_rd_wren_M = 1'b1; bus.i_rd_addr_M = 5'd5; bus.i_rs1_addr_E = 5'd5;
    e = e_base(); e.fa = 2'b01; step("fwd_m_a", e);
    clr(); bus.i_rd_wren_M = 1'b1; bus.i_rd_wren_W = 1'b1;
    step("fwd_x0", e_base());

    // 2) M priority over W, then W alone, then mixed sources.
    clr(); bus.i_rd_wren_M = 1'b1; bus.i_rd_addr_M = 5'd3; bus.i_rd_wren_W = 1'b1; bus.i_rd_addr_W = 5'd3;
    bus.i_rs2_addr_E = 5'd3;
    e = e_base(); e.fb = 2'b01; step("fwd_mw_b", e);
    bus.i_rd_wren_M = 1'b0;
    e = e_base(); e.fb = 2'b10; step("fwd_w_b", e);
    clr(); bus.i_rd_wren_M = 1'b1; bus.i_rd_addr_M = 5'd4; bus.i_rd_wren_W = 1'b1; bus.i_rd_addr_W = 5'd3;
    bus.i_rs1_addr_E = 5'd4; bus.i_rs2_addr_E = 5'd3;
    e = e_base(); e.fa = 2'b01; e.fb = 2'b10; step("fwd_mix", e);
    bus.i_rd_wren_W = 1'b0;
    e = e_base(); e.fa = 2'b01; step("fwd_w_off", e);

    // 3) Load-use inserts one bubble; ALU result or x0 destination does not.
    clr(); bus.i_rd_wren_E = 1'b1; bus.i_wb_sel_E = 2'b01; bus.i_rd_addr_E = 5'd7; bus.i_rs2_addr_D = 5'd7;
    e = e_base(); e.hpc = 1'b1; e.hfd = 1'b1; e.fde = 1'b1; step("lu", e);
    clr();
    step("lu_release", e_base());
    cmp("lu_stall_cnt", bus.o_stall_cnt, 32'd1);
    bus.i_rd_wren_E = 1'b1; bus.i_wb_sel_E = 2'b00; bus.i_rd_addr_E = 5'd7; bus.i_rs1_addr_D = 5'd7;
    step("lu_alu", e_base());
    bus.i_wb_sel_E = 2'b01; bus.i_rd_addr_E = 5'd0; bus.i_rs1_addr_D = 5'd0;
    step("lu_x0", e_base());

    // 4) Taken branch overrides load-use.
    clr(); bus.i_rd_wren_E = 1'b1; bus.i_wb_sel_E = 2'b01; bus.i_rd_addr_E = 5'd7; bus.i_rs1_addr_D = 5'd7;
    bus.i_br_taken_E = 1'b1;
    e = e_base(); e.ffd = 1'b1; e.fde = 1'b1; step("br_lu", e);
    clr();
    step("br_after", e_base());
    cmp("br_flush_cnt", bus.o_flush_cnt, 32'd1);
    bus.i_mc_op_E = 1'b1; bus.i_br_taken_E = 1'b1;
    e = e_base(); e.ffd = 1'b1; e.fde = 1'b1; step("br_mc", e);
    clr(); bus.i_mc_done = 1'b1;
    step("done_in_run", e_base());

    // 5) Multi-cycle op: done in the req cycle is ignored, real done after five wait cycles.
    clr(); bus.i_mc_op_E = 1'b1; bus.i_mc_done = 1'b1;
    e = e_mchold(); e.req = 1'b1; step("mc_req", e);
    bus.i_mc_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.i_rd_wren_E = 1'b1; bus.i_wb_sel_E = 2'b01; bus.i_rd_addr_E = 5'd9; bus.i_rs1_addr_D = 5'd9;
      end else begin
        bus.i_rd_wren_E = 1'b0;
      end
      step("mc_wait", e_mchold());
    end
    bus.i_rd_wren_E = 1'b0; bus.i_mc_done = 1'b1;
    step("mc_done", e_base());
    clr();
    step("mc_idle", e_base());
    cmp("mc_stall_cnt", bus.o_stall_cnt, 32'd7);

    // 6) Timeout drops the op and sets the sticky error; reset clears it.
    bus.i_mc_op_E = 1'b1;
    e = e_mchold(); e.req = 1'b1; step("to_req", e);
    for (int i = 0; i < MC_TO - 1; i++) begin
      step("to_wait", e_mchold());
    end
    e = e_base(); e.fde = 1'b1; e.fem = 1'b1; step("to_abort", e);
    exp_err = 1'b1;
    clr();
    step("err_sticky", e_base());
    step("err_sticky2", e_base());
    i_rst = 1'b1;
    step("rst_err_hold", e_reset());
    step("rst_err_clr", e_reset());
    i_rst = 1'b0;
    step("post_rst", e_base());

    // Reset in MC_WAIT aborts without an error; a new op issues a fresh request.
    bus.i_mc_op_E = 1'b1;
    e = e_mchold(); e.req = 1'b1; step("abort_req", e);
    step("abort_wait0", e_mchold());
    step("abort_wait1", e_mchold());
    i_rst = 1'b1;
    step("abort_rst", e_reset());
    i_rst = 1'b0; clr();
    step("abort_idle", e_base());
    bus.i_mc_op_E = 1'b1;
    e = e_mchold(); e.req = 1'b1; step("reissue_req", e);
    bus.i_mc_done = 1'b1;
    step("reissue_done", e_base());
    clr();
    step("final_idle", e_base());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
